// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with EX/MEM/WB forwarding, load-use stall and
// a valid/ready ID/EX pipeline register.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int NREGS_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  rf_rd_en1,
  output logic                  rf_rd_en2,
  output logic [NREGS_LOG2-1:0] rf_rd_addr1,
  output logic [NREGS_LOG2-1:0] rf_rd_addr2,
  input  logic [XLEN-1:0]       rf_rd_data1,
  input  logic [XLEN-1:0]       rf_rd_data2,
  input  logic                  ex_wr_en,
  input  logic [NREGS_LOG2-1:0] ex_wr_addr,
  input  logic [XLEN-1:0]       ex_wr_data,
  input  logic                  ex_is_load,
  input  logic                  mem_wr_en,
  input  logic [NREGS_LOG2-1:0] mem_wr_addr,
  input  logic [XLEN-1:0]       mem_wr_data,
  input  logic                  wb_wr_en,
  input  logic [NREGS_LOG2-1:0] wb_wr_addr,
  input  logic [XLEN-1:0]       wb_wr_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_pc,
  output logic [XLEN-1:0]       out_rs1_val,
  output logic [XLEN-1:0]       out_rs2_val,
  output logic [XLEN-1:0]       out_imm,
  output logic [NREGS_LOG2-1:0] out_rd,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic                  out_funct7b5,
  output logic                  out_illegal
);
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;

  logic [6:0] opcode;
  logic is_op, is_opimm, is_load, is_store, is_branch, is_jalr, is_lui, is_auipc, is_jal;
  logic use1, use2, has_rd, illegal, hazard, load, transfer;
  logic [NREGS_LOG2-1:0] rs1, rs2, rd;
  logic signed [31:0] imm32;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;

  assign opcode    = in_instr[6:0];
  assign is_op     = opcode == OP;
  assign is_opimm  = opcode == OP_IMM;
  assign is_load   = opcode == LOAD;
  assign is_store  = opcode == STORE;
  assign is_branch = opcode == BRANCH;
  assign is_jalr   = opcode == JALR;
  assign is_lui    = opcode == LUI;
  assign is_auipc  = opcode == AUIPC;
  assign is_jal    = opcode == JAL;

  assign use1    = is_op | is_opimm | is_load | is_store | is_branch | is_jalr;
  assign use2    = is_op | is_store | is_branch;
  assign has_rd  = is_op | is_opimm | is_load | is_lui | is_auipc | is_jal | is_jalr;
  assign illegal = !(use1 | has_rd);

  assign rs1 = in_instr[15 +: NREGS_LOG2];
  assign rs2 = in_instr[20 +: NREGS_LOG2];
  assign rd  = has_rd ? in_instr[7 +: NREGS_LOG2] : '0;

  always_comb
    imm32 = (is_opimm | is_load | is_jalr) ? {{20{in_instr[31]}}, in_instr[31:20]} :
            is_store  ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
            is_branch ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
            (is_lui | is_auipc) ? {in_instr[31:12], 12'b0} :
            is_jal    ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
            '0;

  assign imm = XLEN'(imm32);

  // A loading EX result is not yet available; the hazard stall covers that case.
  function automatic logic [XLEN-1:0] resolve(input logic used, input logic [NREGS_LOG2-1:0] a,
                                              input logic [XLEN-1:0] rf);
    resolve = (!used || a == '0) ? '0 :
              (ex_wr_en && !ex_is_load && ex_wr_addr == a) ? ex_wr_data :
              (mem_wr_en && mem_wr_addr == a) ? mem_wr_data :
              (wb_wr_en && wb_wr_addr == a) ? wb_wr_data : rf;
  endfunction

  assign rs1_val = resolve(use1, rs1, rf_rd_data1);
  assign rs2_val = resolve(use2, rs2, rf_rd_data2);

  assign rf_rd_en1   = rst_n & in_valid & use1;
  assign rf_rd_en2   = rst_n & in_valid & use2;
  assign rf_rd_addr1 = rs1;
  assign rf_rd_addr2 = rs2;

  assign hazard   = in_valid & ex_wr_en & ex_is_load & (ex_wr_addr != '0) &
                    ((use1 & (ex_wr_addr == rs1)) | (use2 & (ex_wr_addr == rs2)));
  assign load     = !out_valid | out_ready;
  assign in_ready = rst_n & load & !hazard & !flush;
  assign transfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_val  <= '0;
      out_rs2_val  <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= transfer;
      if (transfer) begin
        out_pc       <= in_pc;
        out_rs1_val  <= rs1_val;
        out_rs2_val  <= rs2_val;
        out_imm      <= imm;
        out_rd       <= rd;
        out_opcode   <= opcode;
        out_funct3   <= in_instr[14:12];
        out_funct7b5 <= in_instr[30];
        out_illegal  <= illegal;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against an arithmetic
// reference of RV32I decode, forwarding priority and the ID/EX handshake.
module tb_decode_stage;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic        rf_rd_en1, rf_rd_en2;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic        ex_wr_en = 0, ex_is_load = 0, mem_wr_en = 0, wb_wr_en = 0;
  logic [4:0]  ex_wr_addr = 0, mem_wr_addr = 0, wb_wr_addr = 0;
  logic [31:0] ex_wr_data = 0, mem_wr_data = 0, wb_wr_data = 0;
  logic        flush = 0, out_valid, out_ready = 1;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5, out_illegal;

  int checks = 0, failures = 0;
  logic [31:0] regs [32];

  logic        m_valid = 0, m_f7 = 0, m_ill = 0;
  logic [31:0] m_pc = 0, m_rs1 = 0, m_rs2 = 0, m_imm = 0;
  logic [4:0]  m_rd = 0;
  logic [6:0]  m_op = 0;
  logic [2:0]  m_f3 = 0;

  typedef struct packed {
    logic u1, u2, ill;
    logic [4:0] rd;
    logic [31:0] imm;
  } dec_t;

  always #5 clk = ~clk;

  assign rf_rd_data1 = regs[rf_rd_addr1];
  assign rf_rd_data2 = regs[rf_rd_addr2];

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_imm(out_imm), .out_rd(out_rd), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Immediates as signed integer sums of their scattered fields.
  function automatic dec_t ref_dec(input logic [31:0] i);
    dec_t d;
    int s, v;
    d = '0;
    s = i[31] ? -1 : 0;
    v = 0;
    case (i[6:0])
      7'b0110011: begin d.u1 = 1; d.u2 = 1; d.rd = i[11:7]; end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        d.u1 = 1; d.rd = i[11:7]; v = s * 2048 + int'(i[30:20]);
      end
      7'b0100011: begin
        d.u1 = 1; d.u2 = 1; v = s * 2048 + int'(i[30:25]) * 32 + int'(i[11:7]);
      end
      7'b1100011: begin
        d.u1 = 1; d.u2 = 1;
        v = s * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin d.rd = i[11:7]; v = int'(i & 32'hFFFFF000); end
      7'b1101111: begin
        d.rd = i[11:7];
        v = s * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      end
      default: d.ill = 1;
    endcase
    d.imm = 32'(v);
    return d;
  endfunction

  function automatic logic [31:0] ref_val(input logic used, input logic [4:0] a);
    logic        en [3];
    logic [4:0]  ad [3];
    logic [31:0] dt [3];
    en = '{ex_wr_en && !ex_is_load, mem_wr_en, wb_wr_en};
    ad = '{ex_wr_addr, mem_wr_addr, wb_wr_addr};
    dt = '{ex_wr_data, mem_wr_data, wb_wr_data};
    if (!used || a == 0) return 0;
    for (int k = 0; k < 3; k++)
      if (en[k] && ad[k] == a) return dt[k];
    return regs[a];
  endfunction

  task automatic cycle();
    dec_t d;
    logic haz, rdy;
    d = ref_dec(in_instr);
    haz = in_valid && ex_wr_en && ex_is_load && ex_wr_addr != 0 &&
          ((d.u1 && ex_wr_addr == in_instr[19:15]) || (d.u2 && ex_wr_addr == in_instr[24:20]));
    rdy = (!m_valid || out_ready) && !haz && !flush;
    #1;
    chk("in_ready", in_ready, rdy);
    chk("rd_en1", rf_rd_en1, in_valid && d.u1);
    chk("rd_en2", rf_rd_en2, in_valid && d.u2);
    if (rf_rd_en1) chk("rd_addr1", rf_rd_addr1, in_instr[19:15]);
    if (rf_rd_en2) chk("rd_addr2", rf_rd_addr2, in_instr[24:20]);
    if (flush) m_valid = 0;
    else if (!m_valid || out_ready) begin
      m_valid = in_valid && rdy;
      if (m_valid) begin
        m_pc = in_pc; m_rs1 = ref_val(d.u1, in_instr[19:15]); m_rs2 = ref_val(d.u2, in_instr[24:20]);
        m_imm = d.imm; m_rd = d.rd; m_op = in_instr[6:0]; m_f3 = in_instr[14:12];
        m_f7 = in_instr[30]; m_ill = d.ill;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_rs1_val", out_rs1_val, m_rs1);
      chk("out_rs2_val", out_rs2_val, m_rs2);
      chk("out_imm", out_imm, m_imm);
      chk("out_rd", out_rd, m_rd);
      chk("out_opcode", out_opcode, m_op);
      chk("out_funct3", out_funct3, m_f3);
      chk("out_funct7b5", out_funct7b5, m_f7);
      chk("out_illegal", out_illegal, m_ill);
    end
  endtask

  task automatic fwd(input logic e, input logic m, input logic w);
    ex_wr_en = e; ex_wr_addr = 5; ex_wr_data = 32'h11;
    mem_wr_en = m; mem_wr_addr = 5; mem_wr_data = 32'h22;
    wb_wr_en = w; wb_wr_addr = 5; wb_wr_data = 32'h33;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rd_en1", rf_rd_en1, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_rs1", out_rs1_val, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_opcode", out_opcode, 0);
    chk("rst_out_illegal", out_illegal, 0);
  endtask

  initial begin
    logic [6:0] ops [11];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0F};
    regs[0] = 0;
    for (int r = 1; r < 32; r++) regs[r] = $urandom;
    // Reset held with a valid instruction presented
    in_valid = 1; in_instr = 32'h00128333; in_pc = 32'h100;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1;
    // Forwarding priority
    fwd(1, 1, 1);
    in_instr = 32'h00700293; in_pc = 32'h104; cycle();
    chk("addi_x0_rs1", out_rs1_val, 32'h0);
    chk("addi_imm", out_imm, 32'h7);
    in_instr = 32'h00528333; in_pc = 32'h108; cycle();
    chk("fwd_ex_rs1", out_rs1_val, 32'h11);
    chk("fwd_ex_rs2", out_rs2_val, 32'h11);
    fwd(0, 1, 1); in_pc = 32'h10C; cycle();
    chk("fwd_mem", out_rs1_val, 32'h22);
    fwd(0, 0, 1); in_pc = 32'h110; cycle();
    chk("fwd_wb", out_rs2_val, 32'h33);
    fwd(0, 0, 0);
    // Load-use stall, then release with a MEM value for x5
    ex_wr_en = 1; ex_wr_addr = 5; ex_is_load = 1; ex_wr_data = 32'hDEAD;
    in_instr = 32'h00128333; in_pc = 32'h114; cycle();
    chk("loaduse_bubble", out_valid, 0);
    ex_is_load = 0; ex_wr_en = 0; mem_wr_en = 1; mem_wr_addr = 5; mem_wr_data = 32'h44;
    cycle();
    chk("loaduse_rs1", out_rs1_val, 32'h44);
    chk("loaduse_rs2", out_rs2_val, regs[1]);
    mem_wr_en = 0;
    // Backpressure
    in_instr = 32'h00100093; in_pc = 32'h118; cycle();
    out_ready = 0; in_instr = 32'hABCDE0B7; in_pc = 32'h11C;
    repeat (3) cycle();
    chk("bp_hold_pc", out_pc, 32'h118);
    out_ready = 1; cycle();
    chk("lui_imm", out_imm, 32'hABCDE000);
    chk("lui_rd", out_rd, 5'd1);
    // Branch and jump immediates
    in_instr = 32'hFE000EE3; in_pc = 32'h120; cycle();
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    in_instr = 32'h0040006F; in_pc = 32'h124; cycle();
    chk("jal_imm", out_imm, 32'h4);
    // Flush drops the presented instruction
    flush = 1; in_instr = 32'h00528333; in_pc = 32'h128; cycle();
    chk("flush_drop", out_valid, 0);
    flush = 0;
    // Illegal opcode
    in_instr = 32'hFFFFFFFF; in_pc = 32'h12C; cycle();
    chk("illegal_flag", out_illegal, 1);
    chk("illegal_rd", out_rd, 0);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = $urandom;
      in_instr[6:0] = ops[$urandom_range(0, 10)];
      in_instr[19:15] = 5'($urandom_range(0, 3));
      in_instr[24:20] = 5'($urandom_range(0, 3));
      in_pc = $urandom;
      ex_wr_en = $urandom_range(0, 1); ex_wr_addr = 5'($urandom_range(0, 3));
      ex_wr_data = $urandom; ex_is_load = $urandom_range(0, 2) == 0;
      mem_wr_en = $urandom_range(0, 1); mem_wr_addr = 5'($urandom_range(0, 3)); mem_wr_data = $urandom;
      wb_wr_en = $urandom_range(0, 1); wb_wr_addr = 5'($urandom_range(0, 3)); wb_wr_data = $urandom;
      flush = $urandom_range(0, 7) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    // Asynchronous reset mid-transfer discards the instruction
    flush = 0; ex_wr_en = 0; out_ready = 1; in_valid = 1; in_instr = 32'h00528333;
    #2;
    rst_n = 0;
    #1;
    m_valid = 0;
    check_reset_outputs();
    @(posedge clk);
    #1;
    chk("rst_hold_valid", out_valid, 0);
    rst_n = 1;
    in_pc = 32'h200; cycle();
    chk("post_rst_pc", out_pc, 32'h200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
